// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: in-order write-back (port A) always wins;
// late results (port B) wait in a small FIFO and drain into idle write cycles.
module grf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        WriteEn,
    output logic [4:0]  RegWrite,
    output logic [31:0] WData,
    input  logic [4:0]  pend_q1,
    input  logic [4:0]  pend_q2,
    output logic        pend_hit1,
    output logic        pend_hit2,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [DEPTH-1:0]          live_q, live_d;
    logic [DEPTH-1:0][4:0]     fifo_reg_q, fifo_reg_d;
    logic [DEPTH-1:0][31:0]    fifo_data_q, fifo_data_d;
    logic                      we_q, we_d;
    logic [4:0]                waddr_q, waddr_d;
    logic [31:0]               wdata_q, wdata_d;

    logic                      full_s, empty_s;
    logic                      push_s, store_s, pop_s, sup_s;
    logic [DEPTH-1:0]          occ_s;
    logic                      hit1_s, hit2_s;

    // Entry i is occupied when its distance from the read pointer is below the count.
    function automatic logic [DEPTH-1:0] occ_mask(input logic [AW-1:0] rd,
                                                  input logic [CW-1:0] cnt);
        logic [AW-1:0] off;
        occ_mask = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off         = AW'(i) - rd;
            occ_mask[i] = ({1'b0, off} < cnt);
        end
    endfunction

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CW{1'b0}});
    assign push_s  = b_valid & ~full_s;
    // A push to r0 completes the handshake but nothing is stored.
    assign store_s = push_s & (b_reg != 5'd0);
    assign pop_s   = ~a_valid & ~empty_s;
    assign sup_s   = a_valid & (a_reg != 5'd0);
    assign occ_s   = occ_mask(rd_ptr_q, count_q);

    // Next-state for FIFO storage, pointers, count and write-port selection.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        live_d      = live_q;
        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        if (a_valid) begin
            we_d    = (a_reg != 5'd0);
            waddr_d = a_reg;
            wdata_d = a_data;
        end else if (!empty_s) begin
            we_d    = live_q[rd_ptr_q];
            waddr_d = fifo_reg_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
        end else begin
            we_d    = 1'b0;
        end

        if (pop_s) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d         = rd_ptr_q;
        end

        if (store_s) begin
            fifo_reg_d[wr_ptr_q]  = b_reg;
            fifo_data_d[wr_ptr_q] = b_data;
            live_d[wr_ptr_q]      = 1'b1;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d              = wr_ptr_q;
        end

        // Supersession sees the entry stored this cycle, so a same-cycle push dies too.
        if (sup_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_d[i] = live_d[i] & (fifo_reg_d[i] != a_reg);
            end
        end else begin
            live_d = live_d;
        end

        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            live_q      <= {DEPTH{1'b0}};
            fifo_reg_q  <= {(DEPTH*5){1'b0}};
            fifo_data_q <= {(DEPTH*32){1'b0}};
            we_q        <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            live_q      <= live_d;
            fifo_reg_q  <= fifo_reg_d;
            fifo_data_q <= fifo_data_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Pending-write lookup over live, occupied entries only.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_s = hit1_s | (occ_s[i] & live_q[i] & (fifo_reg_q[i] == pend_q1));
            hit2_s = hit2_s | (occ_s[i] & live_q[i] & (fifo_reg_q[i] == pend_q2));
        end
    end

    assign pend_hit1 = hit1_s & (pend_q1 != 5'd0);
    assign pend_hit2 = hit2_s & (pend_q2 != 5'd0);
    assign b_ready   = ~full_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign WriteEn   = we_q;
    assign RegWrite  = waddr_q;
    assign WData     = wdata_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_reg = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_reg = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        WriteEn;
    logic [4:0]  RegWrite;
    logic [31:0] WData;
    logic [4:0]  pend_q1 = 5'd0;
    logic [4:0]  pend_q2 = 5'd0;
    logic        pend_hit1, pend_hit2, full, empty;

    grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .WriteEn(WriteEn), .RegWrite(RegWrite), .WData(WData),
        .pend_q1(pend_q1), .pend_q2(pend_q2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          exp_we   = 1'b0;
    logic [4:0]  exp_reg  = 5'd0;
    logic [31:0] exp_data = 32'd0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].live && q[i].r == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all();
        check_val("WriteEn",   32'(WriteEn),   32'(exp_we));
        if (exp_we) begin
            check_val("RegWrite", 32'(RegWrite), 32'(exp_reg));
            check_val("WData",    WData,         exp_data);
        end
        check_val("b_ready",   32'(b_ready),   32'(q.size() < DEPTH));
        check_val("full",      32'(full),      32'(q.size() == DEPTH));
        check_val("empty",     32'(empty),     32'(q.size() == 0));
        check_val("pend_hit1", 32'(pend_hit1), 32'(model_hit(pend_q1)));
        check_val("pend_hit2", 32'(pend_hit2), 32'(model_hit(pend_q2)));
    endtask

    // One clock cycle: drive at negedge, check, advance the model, wait for the next negedge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] q1, input logic [4:0] q2);
        ent_t e;
        bit   push;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        pend_q1 = q1; pend_q2 = q2;
        #1;
        compare_all();
        push = bv && (q.size() < DEPTH);
        if (av) begin
            exp_we = (ar != 5'd0); exp_reg = ar; exp_data = ad;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            exp_we = e.live; exp_reg = e.r; exp_data = e.d;
        end else begin
            exp_we = 1'b0;
        end
        if (push && br != 5'd0) q.push_back('{r: br, d: bd, live: 1'b1});
        if (av && ar != 5'd0) foreach (q[i]) if (q[i].r == ar) q[i].live = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_val("rst_WriteEn",  32'(WriteEn),  32'd0);
        check_val("rst_RegWrite", 32'(RegWrite), 32'd0);
        check_val("rst_WData",    WData,         32'd0);
        check_val("rst_empty",    32'(empty),    32'd1);
        check_val("rst_b_ready",  32'(b_ready),  32'd1);
        reset = 1'b1;

        // Port A priority: A writes regs 1..5 back to back while B buffers reg 8.
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd8, 32'h1234, 5'd8, 5'd0);
        for (int k = 2; k <= 5; k++) step(1'b1, 5'(k), 32'(k * 256), 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
        idle(3, 5'd8, 5'd0);

        // Full and pointer wrap: 6 push attempts under A traffic, then drain/refill.
        for (int k = 0; k < 6; k++) step(1'b1, 5'd20, 32'(k), 1'b1, 5'(10 + k), 32'(32'hB000 + k), 5'd10, 5'd13);
        idle(5, 5'd11, 5'd12);
        for (int k = 0; k < 4; k++) step(1'b1, 5'd21, 32'(k), 1'b1, 5'(16 + k), 32'(32'hC000 + k), 5'd17, 5'd19);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'hC0FF, 5'd16, 5'd22);
        idle(6, 5'd19, 5'd22);

        // Supersession of a buffered reg 9 by an A write.
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAAAA, 5'd9, 5'd0);
        step(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        idle(3, 5'd9, 5'd0);
        // Same-cycle push and supersession of the same register.
        step(1'b1, 5'd12, 32'h12, 1'b1, 5'd12, 32'hDD, 5'd12, 5'd0);
        idle(2, 5'd12, 5'd0);

        // Register 0 on both ports.
        step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 5'd0, 5'd0);
        idle(2, 5'd0, 5'd0);

        // Pending lookup on regs 3 and 7.
        step(1'b1, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
        step(1'b1, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd3, 5'd0);
        step(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
        idle(3, 5'd3, 5'd7);

        // Reset mid-operation with three entries buffered.
        for (int k = 0; k < 3; k++) step(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'(3 + k), 32'(k + 1), 5'd3, 5'd4);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_WriteEn",  32'(WriteEn),   32'd0);
        check_val("mid_rst_RegWrite", 32'(RegWrite),  32'd0);
        check_val("mid_rst_WData",    WData,          32'd0);
        check_val("mid_rst_empty",    32'(empty),     32'd1);
        check_val("mid_rst_full",     32'(full),      32'd0);
        check_val("mid_rst_b_ready",  32'(b_ready),   32'd1);
        check_val("mid_rst_hit1",     32'(pend_hit1), 32'd0);
        check_val("mid_rst_hit2",     32'(pend_hit2), 32'd0);
        q.delete();
        exp_we = 1'b0; exp_reg = 5'd0; exp_data = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        idle(3, 5'd3, 5'd4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd0);
        idle(2, 5'd6, 5'd0);

        // Random traffic over a narrow register range to provoke collisions.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 9)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 9)), $urandom,
                 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
        end
        idle(6, 5'd1, 5'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-side front end for the general register file: merges the in-order pipeline write-back stream (port A) with late results from multi-cycle units such as the multiply/divide unit (port B) into the register file's single write port. Port A never stalls and always has priority. Port B results are buffered in a small FIFO and drained into idle write-port cycles. A pending-write lookup lets decode stall on registers whose buffered result has not yet landed.

## Interface
- DEPTH, 4, port-B FIFO entries; power of two, ≥ 2.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- a_valid  input  1  pipeline write-back valid this cycle; always accepted.
- a_reg  input  5  destination register.
- a_data  input  32  write data.
- b_valid  input  1  late-result valid.
- b_ready  output  1  FIFO can accept; equals !full.
- b_reg  input  5  late-result destination register.
- b_data  input  32  late-result data.
- WriteEn  output  1  register-file write enable (registered).
- RegWrite  output  5  register-file write address (registered).
- WData  output  32  register-file write data (registered).
- pend_q1, pend_q2  input  5 each  decode lookup addresses.
- pend_hit1, pend_hit2  output  1 each  a live FIFO entry targets pend_qN (combinational).
- full, empty  output  1 each  FIFO status.

## Operation
- FIFO: DEPTH entries of {live, reg[4:0], data[31:0]}; read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- Push: b_valid & b_ready. b_reg == 0 is handshaken but not stored (discarded).
- Output select each cycle, registered at the edge:
  - a_valid: WriteEn=(a_reg≠0), RegWrite=a_reg, WData=a_data. No pop.
  - else if !empty: pop head; WriteEn=head.live, RegWrite=head.reg, WData=head.data.
  - else: WriteEn=0; RegWrite and WData hold.
- Supersession: an a_valid write to R≠0 clears live on every FIFO entry with reg==R, including an entry pushed in the same cycle. Dead entries are still popped in order, with WriteEn=0 in the pop cycle.
- Simultaneous push and pop: allowed when not full; count unchanged.
- When full, b_ready=0 even if a pop occurs that cycle.
- pend_hitN = (pend_qN≠0) & OR over occupied entries of (live & reg==pend_qN). Pure function of the current FIFO contents; the port inputs do not affect it.
- Reset (async assert, at any time): pointers and count 0, all live bits 0, WriteEn=0, RegWrite=0, WData=0, empty=1, full=0, b_ready=1, pend_hit1/2=0. Any in-flight entries are lost.

## Timing
- Port A: valid in cycle t → WriteEn/RegWrite/WData present in cycle t+1. Fixed 1-cycle latency; never delayed.
- Port B: accepted in cycle t into an empty FIFO, with a_valid=0 in t+1 → popped in t+1, output present in t+2. Each cycle with a_valid=1 delays the drain by one cycle.
- b_ready, full, empty: from registered count, stable for the whole cycle.
- pend_hitN: updates the cycle after a push, pop, or supersession edge.
- Reset deassertion: first push can be accepted in the first cycle after release.

## Test plan
- Reset mid-operation: FIFO holds 3 entries, pull reset low between edges → outputs zero immediately, empty=1, b_ready=1. After release, no stale write appears.
- A priority: a_valid=1 for 5 cycles (regs 1..5) while B pushes reg 8 = 0x1234 → A writes appear in cycles 1..5. Reg 8 write appears in the first cycle after a_valid drops.
- Full/wrap: DEPTH=4, a_valid held 1 while 6 B pushes are attempted → exactly 4 accepted, b_ready=0 afterwards. Drain 4, push 4 more → pointer wrap, data in FIFO order, full/empty correct at each step.
- Supersession: B pushes reg 9 = 0xAAAA, then A writes reg 9 = 0xBBBB → pend_hit(9) goes 1 then 0. Drain cycle for that entry shows WriteEn=0. The 0xBBBB write is not overwritten.
- Register 0: A to reg 0 → WriteEn=0. B push to reg 0 → handshake completes, count unchanged, no write.
- Pending lookup: entries for regs 3 and 7 buffered, pend_q1=3, pend_q2=0 → pend_hit1=1, pend_hit2=0. After reg 3 is popped, pend_hit1=0 the next cycle.
